mult_sequencer: RTL

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/mult_sequencer.sv
// Shift-add signed 8x8 sequential multiplier controller with an external adder/subtractor.
// Optional MULT_SEQ_SKIPADD_EN: SHIFT jumps straight to SHIFT when the next multiplier bit is 0.
module mult_sequencer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       ClearA_LoadB,
    input  logic [7:0] S,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_sub,
    input  logic [8:0] add_sum,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       Xval,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t     state;
    logic [2:0] cnt;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [7:0] m_reg;
    logic       x_reg;

    assign add_a = a_reg;
    assign add_b = m_reg;
    assign Aval  = a_reg;
    assign Bval  = b_reg;
    assign Xval  = x_reg;

    // NOTE: every register here, including M, is cleared by the async reset so an aborted
    // operation leaves no partial result behind; all state updates use non-blocking assignments.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            a_reg   <= 8'd0;
            b_reg   <= 8'd0;
            m_reg   <= 8'd0;
            x_reg   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            add_sub <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        a_reg   <= 8'd0;
                        x_reg   <= 1'b0;
                        m_reg   <= S;
                        cnt     <= 3'd0;
                        state   <= ADD;
                        busy    <= 1'b1;
                        add_sub <= 1'b0;
                    end else if (ClearA_LoadB) begin
                        a_reg <= 8'd0;
                        x_reg <= 1'b0;
                        b_reg <= S;
                    end
                end

                ADD: begin
                    if (b_reg[0]) begin
                        a_reg <= add_sum[7:0];
                        x_reg <= add_sum[8];
                    end
                    add_sub <= 1'b0;
                    state   <= SHIFT;
                end

                SHIFT: begin
                    a_reg <= {x_reg, a_reg[7:1]};
                    b_reg <= {a_reg[0], b_reg[7:1]};
                    cnt   <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`ifdef MULT_SEQ_SKIPADD_EN
                    end else if (!b_reg[1]) begin
                        // Next multiplier bit is zero: the ADD would be a no-op.
                        state <= SHIFT;
`endif
                    end else begin
                        state   <= ADD;
                        // Sign bit of the multiplier carries negative weight: subtract on the last ADD.
                        add_sub <= (cnt == 3'd6);
                    end
                end

                DONE: begin
                    if (!Run) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    add_sub <= 1'b0;
                end
            endcase
        end
    end

endmodule
